// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory port (read enable, word address,
// response) plus the decode-facing instruction queue head and redirect inputs.
interface instr_fetch_unit_if;
  logic        EN;
  logic        REDIRECT;
  logic [15:0] REDIRECT_PC;
  logic        MEM_RDEN1;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_DOUT1;
  logic        memValid1;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [15:0] INSTR_PC;
  logic        INSTR_READY;
  logic        FETCH_FAULT;

  modport master (
    input  EN, REDIRECT, REDIRECT_PC, MEM_DOUT1, memValid1, INSTR_READY,
    output MEM_RDEN1, MEM_ADDR1, INSTR_VALID, INSTR, INSTR_PC, FETCH_FAULT
  );

  modport slave (
    output EN, REDIRECT, REDIRECT_PC, MEM_DOUT1, memValid1, INSTR_READY,
    input  MEM_RDEN1, MEM_ADDR1, INSTR_VALID, INSTR, INSTR_PC, FETCH_FAULT
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word reads, tracks hit/miss responses, queues
// {instruction, PC} for decode and handles redirects without breaking a fill.
module instr_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input logic                  MEM_CLK,
  input logic                  RST_N,
  instr_fetch_unit_if.master   bus
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] PC_LIMIT = 16'h6000;

  typedef enum logic [1:0] {FETCH, DRAIN, FAULT} state_t;

  state_t             state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        target_q, target_d;
  logic               busy_q;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]     count_q;
  logic [31:0]        instr_mem [FIFO_DEPTH];
  logic [15:0]        pc_mem    [FIFO_DEPTH];

  logic        full, issue, rden, done, push, pop;
  logic [15:0] redir_pc;

  assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign issue    = (state_q == FETCH) && bus.EN && !full && (pc_q < PC_LIMIT);
  // Gated by reset so the read enable drops the instant reset asserts, even
  // though the request decision itself is combinational for same-cycle hits.
  assign rden     = RST_N && (busy_q || issue);
  assign done     = rden && bus.memValid1;
  assign redir_pc = bus.REDIRECT_PC & 16'hFFFC;
  assign push     = (state_q == FETCH) && done && !bus.REDIRECT;
  assign pop      = (count_q != '0) && bus.INSTR_READY && !bus.REDIRECT;

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    if (bus.REDIRECT) begin
      if (rden && !bus.memValid1) begin
        state_d  = DRAIN;
        target_d = redir_pc;
      end else begin
        pc_d    = redir_pc;
        state_d = (state_q == FAULT && redir_pc >= PC_LIMIT) ? FAULT : FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (done)                               pc_d    = pc_q + 16'd4;
          else if (!rden && pc_q >= PC_LIMIT)     state_d = FAULT;
        end
        DRAIN: begin
          if (done) begin
            pc_d    = target_q;
            state_d = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      target_q <= '0;
      busy_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      busy_q   <= rden && !bus.memValid1;
      if (bus.REDIRECT) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

  // NOTE: queue storage is deliberately left unreset; entries are only
  // observable while count is non-zero, and count itself is reset.
  always_ff @(posedge MEM_CLK) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.MEM_DOUT1;
      pc_mem[wr_ptr_q]    <= pc_q;
    end
  end

  assign bus.MEM_RDEN1   = rden;
  assign bus.MEM_ADDR1   = pc_q[15:2];
  assign bus.INSTR_VALID = (count_q != '0);
  assign bus.INSTR       = instr_mem[rd_ptr_q];
  assign bus.INSTR_PC    = pc_mem[rd_ptr_q];
  assign bus.FETCH_FAULT = (state_q == FAULT);

endmodule
